dcpu16_mbus_arb: RTL

- Parametrised memory-bus arbiter for the DCPU16 core.
- Merges NCH simplified-Wishbone master channels onto one shared simplified-Wishbone memory port. This generalises the existing fixed split between F-BUS and G-BUS.
- Adds fixed or round-robin arbitration, registered data return, a bus timeout with error signalling, and a pipe-stall output compatible with the core's `ena` convention.
- Sits between the core's bus controller and the single-ported memory/peripheral fabric.

---
 rtl/dcpu16_mbus_pkg.sv | 26 ++
 rtl/dcpu16_mbus_if.sv | 42 ++++
 rtl/dcpu16_mbus_pick.sv | 42 ++++
 rtl/dcpu16_mbus_arb.sv | 132 +++++++++++++
 4 files changed

// File: rtl/dcpu16_mbus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcpu16_mbus_pkg
// Brief    : Shared constants and helpers for the DCPU16 memory-bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dcpu16_mbus_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  // A single channel still needs a 1-bit grant index.
  function automatic int gnt_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int cnt_width(input int tout);
    return (tout > 0) ? $clog2(tout + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcpu16_mbus_if.sv
`default_nettype none
// ============================================================================
// Module   : dcpu16_mbus_if
// Brief    : Channel-side and memory-side signals of the memory-bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dcpu16_mbus_if #(
  parameter int NCH = 2,
  parameter int AW  = 16,
  parameter int DW  = 16
);
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*AW-1:0] c_adr;
  logic [NCH*DW-1:0] c_dto;
  logic [NCH-1:0]    c_stb;
  logic [NCH-1:0]    c_wre;
  logic [NCH-1:0]    c_ack;
  logic [NCH-1:0]    c_err;
  logic [DW-1:0]     c_dti;
  logic [AW-1:0]     m_adr;
  logic [DW-1:0]     m_dto;
  logic              m_stb;
  logic              m_wre;
  logic [DW-1:0]     m_dti;
  logic              m_ack;
  logic              ena;
  logic [GW-1:0]     gnt;

  // Environment side: the channel masters plus the memory fabric.
  modport master (
    output c_adr, c_dto, c_stb, c_wre, m_dti, m_ack,
    input  c_ack, c_err, c_dti, m_adr, m_dto, m_stb, m_wre, ena, gnt
  );

  // Arbiter side.
  modport slave (
    input  c_adr, c_dto, c_stb, c_wre, m_dti, m_ack,
    output c_ack, c_err, c_dti, m_adr, m_dto, m_stb, m_wre, ena, gnt
  );
endinterface
`default_nettype wire

// File: rtl/dcpu16_mbus_pick.sv
`default_nettype none
// ============================================================================
// Module   : dcpu16_mbus_pick
// Brief    : Combinational winner selection, fixed priority or round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module dcpu16_mbus_pick
  import dcpu16_mbus_pkg::*;
#(
  parameter int NCH = 2,
  parameter int GW  = gnt_width(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [GW-1:0]  i_ptr,
  input  logic           i_mode,
  output logic [GW-1:0]  o_idx,
  output logic           o_vld
);

  logic [GW-1:0] w_idx;

  // Round-robin starts one past the last winner; fixed starts at index 0.
  always_comb begin : p_pick
    int   j;
    logic found;
    w_idx = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NCH; k++) begin
      j = i_mode ? ((int'(i_ptr) + 1 + k) % NCH) : k;
      if (!found && i_req[j]) begin
        found = 1'b1;
        w_idx = GW'(j);
      end
    end
  end

  assign o_idx = w_idx;
  assign o_vld = |i_req;

endmodule
`default_nettype wire

// File: rtl/dcpu16_mbus_arb.sv
`default_nettype none
// ============================================================================
// Module   : dcpu16_mbus_arb
// Brief    : Merges NCH simplified-Wishbone channels onto one memory port.
// Revision : 1.0 - initial release
// ============================================================================
module dcpu16_mbus_arb
  import dcpu16_mbus_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int AW   = 16,
  parameter int DW   = 16,
  parameter int PRIO = 0,
  parameter int TOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  dcpu16_mbus_if.slave bus
);

  localparam int            GW      = gnt_width(NCH);
  localparam int            CW      = cnt_width(TOUT);
  localparam logic [CW-1:0] C_TLAST = CW'((TOUT > 0) ? (TOUT - 1) : 0);
  localparam logic          C_MODE  = (PRIO == PRIO_RR);

  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [GW-1:0]  r_ptr;
  logic [GW-1:0]  r_gnt;
  logic [AW-1:0]  r_adr;
  logic [DW-1:0]  r_dto;
  logic           r_wre;
  logic [DW-1:0]  r_dti;
  logic           r_err;
  logic [GW-1:0]  w_pick_idx;
  logic           w_pick_vld;
  logic           w_tmo;
  logic [NCH-1:0] w_ack;
  logic [NCH-1:0] w_err;

  dcpu16_mbus_pick #(
    .NCH (NCH),
    .GW  (GW)
  ) u_pick (
    .i_req  (bus.c_stb),
    .i_ptr  (r_ptr),
    .i_mode (C_MODE),
    .o_idx  (w_pick_idx),
    .o_vld  (w_pick_vld)
  );

  assign w_tmo = (TOUT != 0) && (r_cnt == C_TLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_vld) w_state_nxt = BUSY;
      BUSY:    if (bus.m_ack || w_tmo) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request fields are latched at grant, so the memory side stays stable
  // even if the master changes them after its ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_ptr <= GW'(NCH - 1);
      r_gnt <= '0;
      r_adr <= '0;
      r_dto <= '0;
      r_wre <= 1'b0;
      r_dti <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_gnt <= w_pick_idx;
            r_ptr <= w_pick_idx;
            r_adr <= bus.c_adr[int'(w_pick_idx)*AW +: AW];
            r_dto <= bus.c_dto[int'(w_pick_idx)*DW +: DW];
            r_wre <= bus.c_wre[w_pick_idx];
            r_cnt <= '0;
          end
        end
        BUSY: begin
          if (bus.m_ack) begin
            if (!r_wre) r_dti <= bus.m_dti;
            r_err <= 1'b0;
          end else if (w_tmo) begin
            r_err <= 1'b1;
          end else if (TOUT != 0) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_ack = '0;
    w_err = '0;
    if (r_state == DONE) begin
      if (r_err) w_err[r_gnt] = 1'b1;
      else       w_ack[r_gnt] = 1'b1;
    end
  end

  assign bus.c_ack = w_ack;
  assign bus.c_err = w_err;
  assign bus.c_dti = r_dti;
  assign bus.m_adr = r_adr;
  assign bus.m_dto = r_dto;
  assign bus.m_stb = (r_state == BUSY);
  assign bus.m_wre = (r_state == BUSY) && r_wre;
  assign bus.gnt   = r_gnt;
  assign bus.ena   = &(~bus.c_stb | w_ack | w_err);

endmodule
`default_nettype wire
